// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x-oversampled UART receiver.
// Recovers start + 8 data bits (LSB first) + optional parity + 1 stop bit
// from an asynchronous serial line. Each completed frame is presented on
// data_out with a one-cycle data_valid pulse. The parity and framing status
// of that frame is presented alongside it.
module uart_rx_unit #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       active_flag,
    output logic       done_flag
);

    // Tick divisors, rounded to nearest: (CLK_HZ + baud*8) / (baud*16).
    localparam int DIV_2400  = (CLK_HZ + 2400  * 8) / (2400  * 16);
    localparam int DIV_4800  = (CLK_HZ + 4800  * 8) / (4800  * 16);
    localparam int DIV_9600  = (CLK_HZ + 9600  * 8) / (9600  * 16);
    localparam int DIV_19200 = (CLK_HZ + 19200 * 8) / (19200 * 16);

    // The slowest rate needs the widest divider.
    localparam int CW = $clog2(DIV_2400 + 1);
    localparam int SW = $clog2(OVERSAMPLE);

    // The sample counter value that marks the middle of a bit.
    localparam logic [SW-1:0] MID_SAMPLE = SW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            sync_1;
    logic            rx_s;
    logic            rx_prev;

    logic [1:0]      div_sel;
    logic [CW-1:0]   div_last;
    logic [CW-1:0]   div_cnt;
    logic [SW-1:0]   sample_cnt;
    logic            tick;
    logic            mid;

    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bad;
    logic            parity_sum;

    // FSM strobes produced by the next-state logic.
    logic            start_det;
    logic            false_start;
    logic            shift_en;
    logic            parity_en;
    logic            finish;

    // Two-flop synchroniser plus a delayed copy of rx_s for edge detection.
    // Reset to 1 so that a line that idles high never looks like a start edge.
    always_ff @(posedge clock) begin
        // NOTE: every clocked register uses non-blocking assignment so that
        // all flops sample the values from before the edge.
        if (reset) begin
            sync_1  <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= rx_in;
            rx_s    <= sync_1;
            rx_prev <= rx_s;
        end
    end

    // Pick the terminal count of the tick divider for the latched baud rate.
    always_comb begin
        case (div_sel)
            2'b00:   div_last = CW'(DIV_2400  - 1);
            2'b01:   div_last = CW'(DIV_4800  - 1);
            2'b10:   div_last = CW'(DIV_9600  - 1);
            default: div_last = CW'(DIV_19200 - 1);
        endcase
    end

    assign tick = (state != S_IDLE) && (div_cnt == div_last);
    assign mid  = tick && (sample_cnt == MID_SAMPLE);

    // The divider and the sample counter are held at zero in IDLE. This keeps
    // the tick phase locked to the detected start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt    <= '0;
            sample_cnt <= '0;
            div_sel    <= 2'b00;
        end else begin
            if (start_det) begin
                div_sel <= baud_rate;
            end
            if (state == S_IDLE) begin
                div_cnt    <= '0;
                sample_cnt <= '0;
            end else if (tick) begin
                div_cnt    <= '0;
                sample_cnt <= sample_cnt + SW'(1);
            end else begin
                div_cnt    <= div_cnt + CW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle strobes that drive the datapath.
    always_comb begin
        // NOTE: every combinational output gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        start_det   = 1'b0;
        false_start = 1'b0;
        shift_en    = 1'b0;
        parity_en   = 1'b0;
        finish      = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_next = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (mid) begin
                    if (!rx_s) begin
                        state_next = S_DATA;
                    end else begin
                        state_next  = S_IDLE;
                        false_start = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        if (parity_type == 2'b01 || parity_type == 2'b10) begin
                            state_next = S_PARITY;
                        end else begin
                            state_next = S_STOP;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (mid) begin
                    parity_en  = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (mid) begin
                    finish     = 1'b1;
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // XOR of the eight data bits and the received parity bit: 1 means the
    // total count of ones is odd.
    assign parity_sum = ^{shift_reg, rx_s};

    // Receive datapath: LSB-first shift register, bit counter, parity result.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bad <= 1'b0;
        end else begin
            if (start_det) begin
                bit_cnt    <= 3'd0;
                parity_bad <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (parity_en) begin
                parity_bad <= (parity_type == 2'b01) ? ~parity_sum : parity_sum;
            end
        end
    end

    // Registered outputs. The byte and its status update together with the
    // valid pulse and hold until the next completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            data_valid <= finish;
            if (start_det) begin
                active_flag <= 1'b1;
                done_flag   <= 1'b0;
            end
            if (false_start) begin
                active_flag <= 1'b0;
            end
            if (finish) begin
                data_out     <= shift_reg;
                parity_error <= parity_bad;
                frame_error  <= ~rx_s;
                active_flag  <= 1'b0;
                done_flag    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: self-checking bench for uart_rx_unit.
// A behavioural serial transmitter drives rx_in. A monitor collects every
// data_valid pulse, and the results are compared with table constants and
// with a frame-level reference model.
module tb_uart_rx_unit;

    // A reduced clock rate keeps the frames short: 32..256 clocks per bit.
    localparam int CLK_HZ = 614_400;

    logic       clock;
    logic       reset;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    uart_rx_unit #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_in        (rx_in),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pt;
        logic [1:0] sel;
        logic       bad_par;
        logic       stop_v;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    int      n_checks;
    int      n_fail;
    int      act_cycles;
    rx_rec_t got_q[$];
    rx_rec_t exp_q[$];
    rx_rec_t mon_rec;
    vec_t    vecs[9];

    // Monitor: record every valid cycle and count cycles with active_flag high.
    initial act_cycles = 0;
    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            mon_rec.data = data_out;
            mon_rec.perr = parity_error;
            mon_rec.ferr = frame_error;
            got_q.push_back(mon_rec);
        end
        if (active_flag === 1'b1) begin
            act_cycles = act_cycles + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Clocks per bit from the divisor rule: 16 * round(CLK_HZ / (16*baud)).
    function automatic int bit_clocks(input logic [1:0] sel);
        int baud;
        baud = 2400 << sel;
        return 16 * ((CLK_HZ + baud * 8) / (baud * 16));
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Serial transmitter: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                              input logic bad_par, input logic stop_v,
                              input logic [1:0] sel);
        int   bc;
        logic p;
        bc          = bit_clocks(sel);
        baud_rate   = sel;
        parity_type = pt;
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], bc);
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            p = (pt == 2'b10) ? ^d : ~^d;
            drive_bit(p ^ bad_par, bc);
        end
        drive_bit(stop_v, bc);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_out"},     {24'd0, data_out}, 32'd0);
        check({tag, "_data_valid"},   {31'd0, data_valid}, 32'd0);
        check({tag, "_parity_error"}, {31'd0, parity_error}, 32'd0);
        check({tag, "_frame_error"},  {31'd0, frame_error}, 32'd0);
        check({tag, "_active_flag"},  {31'd0, active_flag}, 32'd0);
        check({tag, "_done_flag"},    {31'd0, done_flag}, 32'd0);
    endtask

    initial begin
        int      bc;
        int      a0;
        int      n_exp;
        int      gap;
        rx_rec_t r;
        rx_rec_t e;
        logic [7:0] rd;
        logic [1:0] rpt;
        logic [1:0] rsel;
        logic       rbad;
        logic       rstop;

        n_checks    = 0;
        n_fail      = 0;
        rx_in       = 1'b1;
        reset       = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b10;

        vecs[0] = '{8'hA5, 2'b00, 2'b10, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 2'b10, 2'b10, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 2'b10, 2'b10, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 2'b11, 2'b11, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 2'b01, 2'b00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 2'b00, 2'b01, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 2'b01, 2'b11, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[7] = '{8'hE1, 2'b11, 2'b11, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0};
        vecs[8] = '{8'h6E, 2'b01, 2'b10, 1'b1, 1'b0, 8'h6E, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;
        idle(4);

        // Table-driven single frames.
        for (int v = 0; v < 9; v++) begin
            bc = bit_clocks(vecs[v].sel);
            got_q.delete();
            a0 = act_cycles;
            send_frame(vecs[v].data, vecs[v].pt, vecs[v].bad_par, vecs[v].stop_v, vecs[v].sel);
            idle(2 * bc);
            check($sformatf("vec%0d_count", v), got_q.size(), 1);
            if (got_q.size() > 0) begin
                r = got_q[0];
                check($sformatf("vec%0d_data", v), {24'd0, r.data}, {24'd0, vecs[v].exp_data});
                check($sformatf("vec%0d_perr", v), {31'd0, r.perr}, {31'd0, vecs[v].exp_perr});
                check($sformatf("vec%0d_ferr", v), {31'd0, r.ferr}, {31'd0, vecs[v].exp_ferr});
            end
            check($sformatf("vec%0d_done", v), {31'd0, done_flag}, 32'd1);
            check($sformatf("vec%0d_active", v), {31'd0, active_flag}, 32'd0);
            if (v == 0) begin
                // Active spans start edge to mid-stop: about 9.5 bit times.
                check("active_len_a5",
                      {31'd0, ((act_cycles - a0) >= 9 * bc) && ((act_cycles - a0) <= 10 * bc)},
                      32'd1);
            end
        end

        // Odd parity, three frames back-to-back with no idle gap.
        got_q.delete();
        bc = bit_clocks(2'b11);
        send_frame(8'h00, 2'b01, 1'b0, 1'b1, 2'b11);
        send_frame(8'hFF, 2'b01, 1'b0, 1'b1, 2'b11);
        send_frame(8'h55, 2'b01, 1'b0, 1'b1, 2'b11);
        idle(2 * bc);
        check("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_data0", {24'd0, got_q[0].data}, 32'h00);
            check("b2b_data1", {24'd0, got_q[1].data}, 32'hFF);
            check("b2b_data2", {24'd0, got_q[2].data}, 32'h55);
            check("b2b_perr",  {29'd0, got_q[0].perr, got_q[1].perr, got_q[2].perr}, 32'd0);
        end

        // Glitch of 4 oversample ticks: false start.
        got_q.delete();
        bc = bit_clocks(2'b10);
        baud_rate = 2'b10;
        drive_bit(1'b0, 4 * (bc / 16));
        check("glitch_active_seen", {31'd0, active_flag}, 32'd1);
        idle(bc);
        check("glitch_active", {31'd0, active_flag}, 32'd0);
        check("glitch_done", {31'd0, done_flag}, 32'd0);
        check("glitch_count", got_q.size(), 0);

        // Stop bit low, then line held low for three frame times.
        got_q.delete();
        send_frame(8'h96, 2'b00, 1'b0, 1'b0, 2'b10);
        drive_bit(1'b0, 30 * bc);
        check("break_count_low", got_q.size(), 1);
        check("break_active_low", {31'd0, active_flag}, 32'd0);
        idle(2 * bc);
        check("break_count_high", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("break_data", {24'd0, got_q[0].data}, 32'h96);
            check("break_ferr", {31'd0, got_q[0].ferr}, 32'd1);
        end
        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 2'b10);
        idle(2 * bc);
        check("after_break_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("after_break_data", {24'd0, got_q[1].data}, 32'h3C);
            check("after_break_ferr", {31'd0, got_q[1].ferr}, 32'd0);
        end

        // Reset pulse in the middle of data bit 4.
        got_q.delete();
        fork
            send_frame(8'hF0, 2'b00, 1'b0, 1'b1, 2'b10);
            begin
                repeat (5 * bc + bc / 2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check_zero_outputs("midreset");
                reset = 1'b0;
            end
        join
        idle(2 * bc);
        check("midreset_count", got_q.size(), 0);
        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 2'b10);
        idle(2 * bc);
        check("post_reset_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("post_reset_data", {24'd0, got_q[0].data}, 32'h81);
            check("post_reset_errs", {30'd0, got_q[0].perr, got_q[0].ferr}, 32'd0);
        end

        // Randomised frames against the frame-level reference model.
        got_q.delete();
        exp_q.delete();
        rsel = 2'b11;
        for (int k = 0; k < 20; k++) begin
            rd    = 8'($urandom);
            rpt   = 2'($urandom_range(0, 3));
            rsel  = 2'($urandom_range(0, 3));
            rbad  = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 7) != 0);
            e.data = rd;
            e.perr = rbad && (rpt == 2'b01 || rpt == 2'b10);
            e.ferr = ~rstop;
            exp_q.push_back(e);
            send_frame(rd, rpt, rbad, rstop, rsel);
            bc  = bit_clocks(rsel);
            gap = rstop ? int'($urandom_range(0, 1)) * bc : bc;
            if (gap > 0) begin
                idle(gap);
            end
        end
        idle(2 * bit_clocks(rsel));
        n_exp = exp_q.size();
        check("rand_count", got_q.size(), n_exp);
        for (int k = 0; k < n_exp && k < got_q.size(); k++) begin
            check($sformatf("rand%0d_data", k), {24'd0, got_q[k].data}, {24'd0, exp_q[k].data});
            check($sformatf("rand%0d_perr", k), {31'd0, got_q[k].perr}, {31'd0, exp_q[k].perr});
            check($sformatf("rand%0d_ferr", k), {31'd0, got_q[k].ferr}, {31'd0, exp_q[k].ferr});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- Receive-side counterpart of the UART transmitter; sits directly downstream of the Tx serial output (data_tx -> rx_in).
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) using a 16x oversampling tick derived internally from the system clock.
- Uses the same parity_type and baud_rate selector encodings as the Tx unit.
- Presents each received byte with one-cycle valid and error flags.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- OVERSAMPLE, 16, samples per bit; fixed at 16 and not overridden.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_in  input  1  serial line, idle high, asynchronous to clock
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none
- baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200 baud
- data_out  output  8  last received byte
- data_valid  output  1  one-cycle pulse when a frame completes
- parity_error  output  1  parity mismatch for the frame in data_out
- frame_error  output  1  stop bit sampled low for the frame in data_out
- active_flag  output  1  high while a frame is being received
- done_flag  output  1  high from frame completion until the next start edge

Behaviour:
- Reset (reset=1 at a clock edge):
  - data_out=0, data_valid=0, parity_error=0, frame_error=0, active_flag=0, done_flag=0.
  - FSM goes to IDLE; tick divider, sample counter and bit counter clear; synchroniser flops set to 1.
  - Reset mid-frame aborts the frame with no data_valid.
- Synchroniser: rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Tick generator:
  - DIV = (CLK_HZ + baud*8) / (baud*16), integer division, computed per baud_rate selection.
  - Counter runs 0..DIV-1 and asserts tick for one cycle at DIV-1.
  - Counter clears in IDLE, so tick phase aligns to the start edge.
  - A change of baud_rate mid-frame is undefined; it takes effect from the next frame.
- Sampling: a 4-bit sample counter advances on each tick; a bit is sampled when the counter is 7 (mid-bit), and each bit spans 16 ticks.
- FSM states:
  - IDLE:
    - A falling edge on rx_s (previous 1, current 0) moves to START.
    - The same edge sets active_flag=1 and done_flag=0.
  - START:
    - At the mid-bit sample, rx_s=0 moves to DATA.
    - rx_s=1 is a false start: return to IDLE, active_flag=0, no flags touched.
  - DATA:
    - Shift rx_s into bit[n] LSB-first at each mid-bit, 8 bits counted 0..7.
    - After bit 7, go to PARITY if parity_type is 01 or 10, otherwise go to STOP.
  - PARITY:
    - Sample the parity bit.
    - Odd parity: the 8 data bits plus the parity bit must have odd total ones.
    - Even parity: the 8 data bits plus the parity bit must have even total ones.
    - The result is stored for the completion cycle.
  - STOP:
    - On the mid-stop sample: data_out <= shifted byte, data_valid=1 for exactly one cycle.
    - parity_error is set if parity was checked and failed, otherwise 0.
    - frame_error = ~rx_s.
    - active_flag=0, done_flag=1.
    - Next state is IDLE if rx_s=1, or BREAK if rx_s=0.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line never re-triggers a frame.
- Completion timing: data_out and the error flags update in the same cycle data_valid pulses. They hold until the next completion or reset.
- Back-to-back frames: because the FSM returns to IDLE at mid-stop, a start edge half a bit after the stop midpoint is accepted.
- No flow control: a new frame overwrites data_out, and the consumer must capture on data_valid.

Test Plan:
- Loopback from the Tx unit with baud_rate=10, parity_type=00, byte 0xA5 -> one data_valid pulse, data_out=0xA5, both error flags 0, active_flag high for about 9.5 bit times.
- Even parity with byte 0x07 and correct parity bit 1 -> data_out=0x07, parity_error=0. Repeat with the parity bit forced to 0 -> parity_error=1, data_valid still pulses.
- Odd parity with bytes 0x00, 0xFF, 0x55 sent back-to-back with no idle gap -> three data_valid pulses carrying 0x00, 0xFF, 0x55 in order, parity_error=0 on all three.
- 0 glitch on rx_in lasting 4 oversample ticks -> false start, no data_valid, returns to IDLE with active_flag=0.
- Stop bit driven 0 followed by a line held low for 3 frame times -> one data_valid with frame_error=1, then no further frames until the line returns high. A subsequent 0x3C frame is received cleanly.
- reset asserted for 1 cycle during data bit 4 of a frame -> all outputs 0 on the next cycle, no data_valid. The next full frame 0x81 is received correctly.
